// File: rtl/sdi_tx_encoder.sv
// SD/HD-SDI transmit encoder: SMPTE x^9+x^4+1 self-synchronizing scrambler
// followed by NRZI, bit-serial LSB first over each 10-bit video word.
// HD/3G/reserved (and SD with bypass) emit the encoded word in the low 10 bits
// of the 20-bit transceiver word. SD with replication repeats every encoded
// bit 11 times through a bit FIFO drained 20 bits per clock.
// In SD mode the tx_ce[0] cadence is checked for 5/6-clock spacing.
// tx_ce_align_err = held cadence verdict OR a one-clock FIFO fault
// (underflow or dropped word).
module sdi_tx_encoder #(
    parameter int FIFO_BITS = 256
) (
    input  logic        clk_400_000,
    input  logic        RESET,
    input  logic [1:0]  tx_mode,
    input  logic [2:0]  tx_ce,
    input  logic        tx_din_rdy,
    input  logic [9:0]  tx_video_a_y_in,
    input  logic        tx_sd_bitrep_bypass,
    output logic [19:0] tx_txdata,
    output logic        tx_ce_align_err
);

    localparam int CW = $clog2(FIFO_BITS + 1) + 1;
    localparam logic [CW-1:0] POP_BITS = CW'(20);
    localparam logic [CW-1:0] REP_BITS = CW'(110);
    localparam logic [CW-1:0] CAP_BITS = CW'(FIFO_BITS);

    // Encoder state
    logic [8:0]           r_scr;        // r_scr[0] is the oldest scrambled bit
    logic                 r_nrzi;       // last NRZI output bit
    logic [19:0]          r_txdata;
    // Replication FIFO, bit 0 is the oldest bit
    logic [FIFO_BITS-1:0] r_fifo;
    logic [CW-1:0]        r_count;
    logic                 r_fifo_err;
    // Mode tracking and cadence checker
    logic [2:0]           r_cfg;
    logic [3:0]           r_cad_cnt;
    logic                 r_cad_seen;
    logic                 r_cad_err;

    logic                 w_accept;
    logic                 w_sd;
    logic                 w_rep;
    logic                 w_cfg_chg;
    logic [18:0]          w_s_ext;      // w_s_ext[j] = s_(j-9) relative to this word
    logic [9:0]           w_enc;
    logic                 w_nrzi_run;
    logic [FIFO_BITS-1:0] w_rep_bits;
    logic [FIFO_BITS-1:0] w_fifo_pre;
    logic [FIFO_BITS-1:0] w_fifo_pop;
    logic [FIFO_BITS-1:0] w_fifo_next;
    logic [CW-1:0]        w_count_pre;
    logic [CW-1:0]        w_count_pop;
    logic [CW-1:0]        w_count_next;
    logic                 w_pop;
    logic                 w_ovf;
    logic                 w_push;
    logic [3:0]           w_cad_cnt_pre;
    logic                 w_cad_seen_pre;
    logic [3:0]           w_interval;
    logic                 w_cad_bad;

    assign w_accept  = tx_ce[0] & tx_din_rdy;
    assign w_sd      = (tx_mode == 2'b01);
    assign w_rep     = w_sd & ~tx_sd_bitrep_bypass;
    // Any change of mode or bypass restarts the FIFO and the cadence checker
    assign w_cfg_chg = ({tx_mode, tx_sd_bitrep_bypass} != r_cfg);

    // Bit-serial scramble then NRZI of the incoming word, chained through history
    always_comb begin
        w_s_ext    = {10'b0, r_scr};
        w_enc      = '0;
        w_nrzi_run = r_nrzi;
        for (int n = 0; n < 10; n++) begin
            w_s_ext[n+9] = tx_video_a_y_in[n] ^ w_s_ext[n+5] ^ w_s_ext[n];
            w_enc[n]     = w_s_ext[n+9] ^ w_nrzi_run;
            w_nrzi_run   = w_enc[n];
        end
    end

    // Expand each encoded bit i into stream positions 11i..11i+10
    always_comb begin
        w_rep_bits = '0;
        for (int i = 0; i < 10; i++) begin
            w_rep_bits[11*i +: 11] = {11{w_enc[i]}};
        end
    end

    // FIFO next state: pop from pre-push content, then append at the new tail
    always_comb begin
        w_count_pre  = w_cfg_chg ? '0 : r_count;
        w_fifo_pre   = w_cfg_chg ? '0 : r_fifo;
        w_pop        = (w_count_pre >= POP_BITS);
        w_count_pop  = w_pop ? (w_count_pre - POP_BITS) : w_count_pre;
        w_fifo_pop   = w_pop ? (w_fifo_pre >> 20) : w_fifo_pre;
        w_ovf        = w_accept & ((w_count_pop + REP_BITS) > CAP_BITS);
        w_push       = w_accept & ~w_ovf;
        w_fifo_next  = w_push ? (w_fifo_pop | (w_rep_bits << w_count_pop)) : w_fifo_pop;
        w_count_next = w_push ? (w_count_pop + REP_BITS) : w_count_pop;
    end

    // Cadence interval measured at the current clock
    always_comb begin
        w_cad_cnt_pre  = w_cfg_chg ? 4'd0 : r_cad_cnt;
        w_cad_seen_pre = w_cfg_chg ? 1'b0 : r_cad_seen;
        w_interval     = w_cad_cnt_pre + 4'd1;
        w_cad_bad      = !((w_interval == 4'd5) || (w_interval == 4'd6)) || (tx_ce != 3'b111);
    end

    // Scrambler/NRZI history advances on every accepted word, dropped or not
    always_ff @(posedge clk_400_000 or posedge RESET) begin
        if (RESET) begin
            r_scr  <= '0;
            r_nrzi <= 1'b0;
            r_cfg  <= '0;
        end else begin
            r_cfg <= {tx_mode, tx_sd_bitrep_bypass};
            if (w_accept) begin
                r_scr  <= w_s_ext[18:10];
                r_nrzi <= w_enc[9];
            end
        end
    end

    // Output word and FIFO: replicated stream in SD, direct word otherwise
    always_ff @(posedge clk_400_000 or posedge RESET) begin
        if (RESET) begin
            r_txdata   <= '0;
            r_fifo     <= '0;
            r_count    <= '0;
            r_fifo_err <= 1'b0;
        end else if (w_rep) begin
            r_fifo     <= w_fifo_next;
            r_count    <= w_count_next;
            r_txdata   <= w_pop ? w_fifo_pre[19:0] : 20'd0;
            r_fifo_err <= ~w_pop | w_ovf;
        end else begin
            r_fifo     <= '0;
            r_count    <= '0;
            r_fifo_err <= 1'b0;
            if (w_accept) begin
                r_txdata <= {10'b0, w_enc};
            end
        end
    end

    // Cadence checker: verdict registered at each pulse and held until the next
    always_ff @(posedge clk_400_000 or posedge RESET) begin
        if (RESET) begin
            r_cad_cnt  <= '0;
            r_cad_seen <= 1'b0;
            r_cad_err  <= 1'b0;
        end else if (!w_sd) begin
            r_cad_cnt  <= '0;
            r_cad_seen <= 1'b0;
            r_cad_err  <= 1'b0;
        end else if (tx_ce[0]) begin
            r_cad_cnt  <= '0;
            r_cad_seen <= 1'b1;
            r_cad_err  <= w_cad_seen_pre & w_cad_bad;
        end else begin
            r_cad_cnt  <= (w_cad_cnt_pre == 4'd14) ? 4'd14 : w_cad_cnt_pre + 4'd1;
            r_cad_seen <= w_cad_seen_pre;
            r_cad_err  <= w_cfg_chg ? 1'b0 : r_cad_err;
        end
    end

    assign tx_txdata       = r_txdata;
    assign tx_ce_align_err = r_cad_err | r_fifo_err;

endmodule

// File: tb/tb_sdi_tx_encoder.sv
// Directed bench for sdi_tx_encoder: reset, HD/reserved encoding with state
// carry, SD bypass, SD 11x replication stream, underflow, cadence errors.
//
// Hand derivation used below (history and NRZI start at 0):
//   word 10'h001: s = bits {0,4,8,9} (s9 = s5^s0 = 1), NRZI -> 10'h10F, o9 = 0
//   then 10'h000: s = bits {2,6,7,8},                  NRZI -> 10'h0BC
module tb_sdi_tx_encoder;

    logic        clk_400_000;
    logic        RESET;
    logic [1:0]  tx_mode;
    logic [2:0]  tx_ce;
    logic        tx_din_rdy;
    logic [9:0]  tx_video_a_y_in;
    logic        tx_sd_bitrep_bypass;
    logic [19:0] tx_txdata;
    logic        tx_ce_align_err;

    int checks = 0;
    int errors = 0;

    sdi_tx_encoder #(.FIFO_BITS(256)) dut (
        .clk_400_000         (clk_400_000),
        .RESET               (RESET),
        .tx_mode             (tx_mode),
        .tx_ce               (tx_ce),
        .tx_din_rdy          (tx_din_rdy),
        .tx_video_a_y_in     (tx_video_a_y_in),
        .tx_sd_bitrep_bypass (tx_sd_bitrep_bypass),
        .tx_txdata           (tx_txdata),
        .tx_ce_align_err     (tx_ce_align_err)
    );

    // Clock
    initial clk_400_000 = 1'b0;
    always #5 clk_400_000 = ~clk_400_000;

    task automatic tick;
        @(posedge clk_400_000);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] mode, input logic byp);
        RESET               = 1'b1;
        tx_mode             = mode;
        tx_sd_bitrep_bypass = byp;
        tx_ce               = 3'b000;
        tx_din_rdy          = 1'b0;
        tx_video_a_y_in     = 10'h000;
        repeat (3) tick();
        RESET = 1'b0;
    endtask

    // gap-1 idle clocks, then one tx_ce pulse clock with no data
    task automatic pulse_after(input int gap, input logic [2:0] ce_val);
        tx_din_rdy = 1'b0;
        tx_ce      = 3'b000;
        repeat (gap - 1) tick();
        tx_ce = ce_val;
        tick();
        tx_ce = 3'b000;
    endtask

    initial begin
        // ---------------- reset and HD idle ----------------
        do_reset(2'b00, 1'b0);
        chk("rst_data", tx_txdata, 20'h00000);
        chk("rst_err", {19'b0, tx_ce_align_err}, 20'h0);
        repeat (3) tick();
        chk("hd_idle_data", tx_txdata, 20'h00000);
        chk("hd_idle_err", {19'b0, tx_ce_align_err}, 20'h0);

        // ---------------- HD word, holds, reserved mode carry ----------------
        tx_video_a_y_in = 10'h001; tx_ce = 3'b111; tx_din_rdy = 1'b1;
        tick();
        chk("hd_word1", tx_txdata, 20'h0010F);
        tx_din_rdy = 1'b0;
        tick();
        chk("hd_hold_rdy0", tx_txdata, 20'h0010F);
        tx_ce = 3'b110; tx_din_rdy = 1'b1;
        tick();
        chk("hd_hold_ce0", tx_txdata, 20'h0010F);
        tx_mode = 2'b11; tx_video_a_y_in = 10'h000; tx_ce = 3'b111; tx_din_rdy = 1'b1;
        tick();
        chk("rsv_word2", tx_txdata, 20'h000BC);
        chk("rsv_err", {19'b0, tx_ce_align_err}, 20'h0);
        tx_ce = 3'b000; tx_din_rdy = 1'b0;
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_data", tx_txdata, 20'h00000);
        RESET = 1'b0;

        // ---------------- SD with bypass ----------------
        do_reset(2'b01, 1'b1);
        tx_video_a_y_in = 10'h001; tx_ce = 3'b111; tx_din_rdy = 1'b1;
        tick();
        chk("sdb_word1", tx_txdata, 20'h0010F);
        chk("sdb_err", {19'b0, tx_ce_align_err}, 20'h0);
        tx_ce = 3'b000; tx_din_rdy = 1'b0;
        tick();
        chk("sdb_hold", tx_txdata, 20'h0010F);

        // ---------------- SD with 11x replication ----------------
        do_reset(2'b01, 1'b0);
        tick(); tick();
        chk("sdr_idle_data", tx_txdata, 20'h00000);
        chk("sdr_idle_uflow", {19'b0, tx_ce_align_err}, 20'h1);
        tx_video_a_y_in = 10'h001; tx_ce = 3'b111; tx_din_rdy = 1'b1;
        tick();                                   // P0: pop sees empty FIFO
        chk("sdr_p0_data", tx_txdata, 20'h00000);
        chk("sdr_p0_uflow", {19'b0, tx_ce_align_err}, 20'h1);
        tx_ce = 3'b000; tx_din_rdy = 1'b0;
        tick();
        chk("sdr_p1", tx_txdata, 20'hFFFFF);
        chk("sdr_p1_err", {19'b0, tx_ce_align_err}, 20'h0);
        tick();
        chk("sdr_p2", tx_txdata, 20'hFFFFF);
        tick();
        chk("sdr_p3", tx_txdata, 20'h0000F);
        tick();
        chk("sdr_p4", tx_txdata, 20'h00000);
        tx_video_a_y_in = 10'h000; tx_ce = 3'b111; tx_din_rdy = 1'b1;
        tick();                                   // P0+5: stream bits 80..99
        chk("sdr_p5", tx_txdata, 20'h7FF00);
        chk("sdr_p5_err", {19'b0, tx_ce_align_err}, 20'h0);
        tx_ce = 3'b000; tx_din_rdy = 1'b0;
        tick();
        chk("sdr_p6", tx_txdata, 20'h00000);
        tick();
        chk("sdr_p7", tx_txdata, 20'hFF000);
        chk("sdr_p7_err", {19'b0, tx_ce_align_err}, 20'h0);
        repeat (3) tick();
        chk("sdr_p10", tx_txdata, 20'h3FF80);
        tick();
        chk("sdr_p11_err", {19'b0, tx_ce_align_err}, 20'h0);
        tick();
        chk("sdr_uflow_data", tx_txdata, 20'h00000);
        chk("sdr_uflow_err", {19'b0, tx_ce_align_err}, 20'h1);

        // ---------------- cadence checker (SD bypass, no FIFO) ----------------
        do_reset(2'b01, 1'b1);
        tx_ce = 3'b111;
        tick();
        tx_ce = 3'b000;
        chk("cad_first", {19'b0, tx_ce_align_err}, 20'h0);
        pulse_after(5, 3'b111);
        chk("cad_5", {19'b0, tx_ce_align_err}, 20'h0);
        pulse_after(6, 3'b111);
        chk("cad_6", {19'b0, tx_ce_align_err}, 20'h0);
        pulse_after(5, 3'b111);
        chk("cad_5b", {19'b0, tx_ce_align_err}, 20'h0);
        pulse_after(4, 3'b111);
        chk("cad_4", {19'b0, tx_ce_align_err}, 20'h1);
        tick();
        chk("cad_4_held", {19'b0, tx_ce_align_err}, 20'h1);
        pulse_after(4, 3'b111);                   // 1 + 4 = interval 5
        chk("cad_clear", {19'b0, tx_ce_align_err}, 20'h0);
        pulse_after(7, 3'b111);
        chk("cad_7", {19'b0, tx_ce_align_err}, 20'h1);
        pulse_after(6, 3'b111);
        chk("cad_6b", {19'b0, tx_ce_align_err}, 20'h0);
        pulse_after(5, 3'b011);
        chk("cad_ce011", {19'b0, tx_ce_align_err}, 20'h1);
        pulse_after(5, 3'b111);
        chk("cad_after011", {19'b0, tx_ce_align_err}, 20'h0);
        chk("cad_data", tx_txdata, 20'h00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
